// File: rtl/uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// uart_mmio_ctrl
//
// Memory-mapped UART sequencer for the RISC-V core. CPU loads and stores that
// fall in the 16-byte window at BASE_ADDR are decoded into a small register
// map. The controller owns two FIFOs:
//   - TX FIFO: filled by CPU stores to offset 0x8, drained into the UART
//     transmitter as a first-word-fall-through stream.
//   - RX FIFO: filled from the UART receiver, drained by CPU loads of 0x4.
// The CPU never waits on the UART: full FIFOs drop bytes and raise sticky flags.
//
// Register map (offset from BASE_ADDR):
//   0x0 status  R : {tx_drop, tx_idle, rx_overrun, rx_not_empty, tx_not_full}
//               W : wbe[0] && wdata[2] clears rx_overrun,
//                   wbe[0] && wdata[4] clears tx_drop
//   0x4 rx data R : head byte of the RX FIFO, popped (0 when empty)
//   0x8 tx data W : wbe[0] pushes wdata[7:0]; reads return 0
//   0xC counts  R : {16'b0, rx_count[7:0], tx_count[7:0]}
//
// Handshakes (both UART sides): a byte moves on a clock edge where valid and
// ready are both high. The producer holds data stable while valid && !ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   addr, wdata, wbe    CPU bus address, store data, store byte enables
//   re                  CPU load strobe (ignored when wbe is nonzero)
//   rdata               registered load data, held until the next load
//   tx_data/valid/ready stream to the UART transmitter
//   rx_data/valid/ready stream from the UART receiver
//   tx_count, rx_count  FIFO occupancies (0..DEPTH)
// ---------------------------------------------------------------------------
module uart_mmio_ctrl #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wbe,
    input  logic             re,
    output logic [31:0]      rdata,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // ---------------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------------
    logic       sel;
    logic [3:0] offset;
    logic       wr_any;
    logic       rd_en;
    logic       hit_status;
    logic       hit_rx;
    logic       hit_tx;
    logic       hit_count;

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset     = addr[3:0];
    assign wr_any     = |wbe;
    // A store in the same cycle wins; the load is dropped entirely.
    assign rd_en      = re && !wr_any;
    assign hit_status = sel && (offset == 4'h0);
    assign hit_rx     = sel && (offset == 4'h4);
    assign hit_tx     = sel && (offset == 4'h8);
    assign hit_count  = sel && (offset == 4'hC);

    // ---------------------------------------------------------------------
    // Storage and pointers
    // ---------------------------------------------------------------------
    logic [7:0]       tx_mem [DEPTH];
    logic [7:0]       rx_mem [DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr;
    logic [PTR_W-1:0] tx_rd_ptr;
    logic [PTR_W-1:0] rx_wr_ptr;
    logic [PTR_W-1:0] rx_rd_ptr;
    logic             rx_overrun;
    logic             tx_drop;

    // ---------------------------------------------------------------------
    // TX FIFO control
    // ---------------------------------------------------------------------
    logic tx_full;
    logic tx_empty;
    logic tx_push_req;
    logic tx_push;
    logic tx_pop;
    logic tx_drop_set;
    logic tx_drop_clr;

    assign tx_full     = (tx_count == FULL_CNT);
    assign tx_empty    = (tx_count == '0);
    assign tx_valid    = !tx_empty;
    assign tx_data     = tx_mem[tx_rd_ptr];
    assign tx_pop      = tx_valid && tx_ready;
    assign tx_push_req = hit_tx && wbe[0];
    // When full, a same-cycle pop frees the slot the push lands in.
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_drop_set = tx_push_req && tx_full && !tx_pop;
    assign tx_drop_clr = hit_status && wbe[0] && wdata[4];

    // ---------------------------------------------------------------------
    // RX FIFO control
    // ---------------------------------------------------------------------
    logic rx_full;
    logic rx_empty;
    logic rx_push_req;
    logic rx_push;
    logic rx_pop;
    logic rx_ovr_set;
    logic rx_ovr_clr;

    assign rx_full     = (rx_count == FULL_CNT);
    assign rx_empty    = (rx_count == '0);
    assign rx_pop      = hit_rx && rd_en && !rx_empty;
    assign rx_push_req = rx_valid && rx_ready;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign rx_ovr_set  = rx_push_req && rx_full && !rx_pop;
    assign rx_ovr_clr  = hit_status && wbe[0] && wdata[2];

    // ---------------------------------------------------------------------
    // Load data
    // ---------------------------------------------------------------------
    logic [7:0]  tx_cnt8;
    logic [7:0]  rx_cnt8;
    logic [31:0] rdata_next;

    assign tx_cnt8 = 8'(tx_count);
    assign rx_cnt8 = 8'(rx_count);

    always_comb begin
        rdata_next = '0;
        if (hit_status) begin
            rdata_next = {27'b0, tx_drop, tx_empty, rx_overrun, !rx_empty, !tx_full};
        end else if (hit_rx) begin
            if (!rx_empty) begin
                rdata_next = {24'b0, rx_mem[rx_rd_ptr]};
            end
        end else if (hit_count) begin
            rdata_next = {16'b0, rx_cnt8, tx_cnt8};
        end
    end

    // ---------------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata      <= '0;
            rx_ready   <= 1'b0;
            tx_wr_ptr  <= '0;
            tx_rd_ptr  <= '0;
            tx_count   <= '0;
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            rx_count   <= '0;
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            // Receiver side is always able to take a byte once out of reset;
            // overflow is handled by dropping, not by back-pressure.
            rx_ready <= 1'b1;

            if (rd_en) begin
                rdata <= rdata_next;
            end

            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            end
            if (tx_push && !tx_pop) begin
                tx_count <= tx_count + 1'b1;
            end else if (!tx_push && tx_pop) begin
                tx_count <= tx_count - 1'b1;
            end

            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            end
            if (rx_push && !rx_pop) begin
                rx_count <= rx_count + 1'b1;
            end else if (!rx_push && rx_pop) begin
                rx_count <= rx_count - 1'b1;
            end

            // Set has priority over clear on the sticky flags.
            if (tx_drop_set) begin
                tx_drop <= 1'b1;
            end else if (tx_drop_clr) begin
                tx_drop <= 1'b0;
            end
            if (rx_ovr_set) begin
                rx_overrun <= 1'b1;
            end else if (rx_ovr_clr) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    // FIFO contents are not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= wdata[7:0];
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

endmodule
